// File: rtl/mips_pipe_pkg.sv
// Shared pipe_MIPS definitions: register-file geometry, write-latency limits,
// and the latency clamp used by both decode and the hazard scoreboard.
package mips_pipe_pkg;

    localparam int NREG    = 32;
    localparam int AW      = $clog2(NREG);
    localparam int MAX_LAT = 4;
    localparam int LATW    = $clog2(MAX_LAT + 1);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [LATW-1:0] lat_t;

    // Zero latency is treated as one cycle; anything above MAX_LAT saturates.
    function automatic lat_t clamp_lat(input lat_t lat);
        lat_t res;
        res = lat;
        if (lat == '0) begin
            res = lat_t'(1);
        end else if (lat > lat_t'(MAX_LAT)) begin
            res = lat_t'(MAX_LAT);
        end
        return res;
    endfunction

endpackage

// File: rtl/sb_lat_cnt.sv
// One register's in-flight write-latency counter. Counts down to zero and
// flags the edge on which the pending write retires.
module sb_lat_cnt
    import mips_pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  lat_t load_val,
    output logic busy,
    output logic done_pulse,
    output logic is_one,
    output logic eq_lat
);

    lat_t cnt_q, cnt_d;
    logic busy_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - lat_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign busy       = busy_q;
    assign is_one     = (cnt_q == lat_t'(1));
    assign done_pulse = is_one && !clr;
    // True when this pending write and a new one of latency load_val would
    // retire on the same edge (this counter decrements while the new one loads).
    assign eq_lat     = ({1'b0, cnt_q} == ({1'b0, load_val} + {{LATW{1'b0}}, 1'b1}));

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// RAW/WAW/write-port hazard scoreboard between decode and issue: one latency
// counter per architectural register, a single write-back strobe per cycle.
module mips_hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter bit BYPASS = 1'b1,
    parameter int STW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [AW-1:0]    issue_rs,
    input  logic [AW-1:0]    issue_rt,
    input  logic [AW-1:0]    issue_rd,
    input  logic             issue_uses_rs,
    input  logic             issue_uses_rt,
    input  logic             issue_writes_rd,
    input  logic [LATW-1:0]  issue_lat,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_rd,
    output logic [NREG-1:0]  busy_mask,
    output logic [STW-1:0]   stall_cnt
);

    logic [NREG-1:0] busy_v, one_v, eq_v, done_v, load_v;
    lat_t            eff_lat;
    logic            raw_rs, raw_rt, waw, port_hz;
    logic            write_en;
    reg_idx_t        done_idx;
    logic            any_done;

    logic            wb_valid_q, wb_valid_d;
    reg_idx_t        wb_rd_q, wb_rd_d;
    logic [STW-1:0]  stall_q, stall_d;

    assign eff_lat = clamp_lat(issue_lat);

    // R0 is hard-wired zero: never busy, never retires.
    assign busy_v[0] = 1'b0;
    assign one_v[0]  = 1'b0;
    assign eq_v[0]   = 1'b0;
    assign done_v[0] = 1'b0;
    assign load_v[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
            assign load_v[gi] = write_en && (issue_rd == AW'(gi));
            sb_lat_cnt u_cnt (
                .clk        (clk),
                .rst        (rst),
                .clr        (flush),
                .load       (load_v[gi]),
                .load_val   (eff_lat),
                .busy       (busy_v[gi]),
                .done_pulse (done_v[gi]),
                .is_one     (one_v[gi]),
                .eq_lat     (eq_v[gi])
            );
        end
    endgenerate

    assign raw_rs  = issue_uses_rs && (issue_rs != '0) && busy_v[issue_rs]
                     && !(BYPASS && one_v[issue_rs]);
    assign raw_rt  = issue_uses_rt && (issue_rt != '0) && busy_v[issue_rt]
                     && !(BYPASS && one_v[issue_rt]);
    assign waw     = issue_writes_rd && (issue_rd != '0) && busy_v[issue_rd];
    assign port_hz = issue_writes_rd && (issue_rd != '0) && (|eq_v);

    assign issue_ready = !flush && !raw_rs && !raw_rt && !waw && !port_hz;
    assign write_en    = issue_valid && issue_ready && issue_writes_rd && (issue_rd != '0);

    // The port check keeps done_v at most one-hot, so a priority encoder suffices.
    always_comb begin
        done_idx = '0;
        for (int i = 1; i < NREG; i++) begin
            if (done_v[i]) begin
                done_idx = AW'(i);
            end
        end
    end
    assign any_done = |done_v;

    always_comb begin
        wb_valid_d = any_done;
        wb_rd_d    = any_done ? done_idx : wb_rd_q;
        stall_d    = stall_q;
        if (issue_valid && !issue_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            stall_q    <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            stall_q    <= stall_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign busy_mask = busy_v;
    assign stall_cnt = stall_q;

endmodule
